// File: rtl/cpu_pkg.sv
// Shared CPU datapath constants and types.
// Register file geometry lives here so decode and writeback agree.
package cpu_pkg;

   localparam int DATA_W = 16;
   localparam int NREGS  = 16;
   localparam int REG_AW = $clog2(NREGS);

   typedef logic [REG_AW-1:0] reg_addr_t;

endpackage

// File: rtl/reg_file_if.sv
// Register file access bundle: write, read and busy-issue signals.
// master = decode/writeback side, slave = the register file.
interface reg_file_if
   import cpu_pkg::*;
#(
   parameter int WIDTH = DATA_W,
   parameter int DEPTH = NREGS
);

   localparam int AW = $clog2(DEPTH);

   logic             we;
   logic [AW-1:0]    waddr;
   logic [WIDTH-1:0] wdata;
   logic             re;
   logic [AW-1:0]    raddr_a;
   logic [AW-1:0]    raddr_b;
   logic [WIDTH-1:0] rdata_a;
   logic [WIDTH-1:0] rdata_b;
   logic             busy_set;
   logic [AW-1:0]    busy_addr;
   logic             busy_a;
   logic             busy_b;

   modport master (
      output we, waddr, wdata,
      output re, raddr_a, raddr_b,
      output busy_set, busy_addr,
      input  rdata_a, rdata_b,
      input  busy_a, busy_b
   );

   modport slave (
      input  we, waddr, wdata,
      input  re, raddr_a, raddr_b,
      input  busy_set, busy_addr,
      output rdata_a, rdata_b,
      output busy_a, busy_b
   );

endinterface

// File: rtl/reg_file_scoreboard.sv
// Per-register busy bits; lookups return the post-update value
// so a same-cycle issue or writeback is already visible.
module reg_file_scoreboard #(
   parameter int DEPTH   = 16,
   parameter int ZERO_R0 = 1,
   localparam int AW     = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          set_i,
   input  logic [AW-1:0] set_addr_i,
   input  logic          clr_i,
   input  logic [AW-1:0] clr_addr_i,
   input  logic [AW-1:0] raddr_a_i,
   input  logic [AW-1:0] raddr_b_i,
   output logic          busy_a_o,
   output logic          busy_b_o
);

   logic [DEPTH-1:0] busy_q;
   logic [DEPTH-1:0] busy_d;

   // Clear first, then set: a freshly issued producer stays outstanding.
   always_comb begin
      busy_d = busy_q;
      if (clr_i) begin
         busy_d[clr_addr_i] = 1'b0;
      end
      if (set_i) begin
         busy_d[set_addr_i] = 1'b1;
      end
      if (ZERO_R0 != 0) begin
         busy_d[0] = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         busy_q <= '0;
      end else begin
         busy_q <= busy_d;
      end
   end

   assign busy_a_o = busy_d[raddr_a_i];
   assign busy_b_o = busy_d[raddr_b_i];

endmodule

// File: rtl/reg_file.sv
// CPU register file: one write port, two registered write-first
// read ports, and per-register busy flags for hazard detection.
module reg_file
   import cpu_pkg::*;
#(
   parameter int WIDTH   = DATA_W,
   parameter int DEPTH   = NREGS,
   parameter int ZERO_R0 = 1
) (
   input  logic       clk,
   input  logic       reset,
   reg_file_if.slave  bus
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic             wr_en;
   logic [WIDTH-1:0] rdata_a_d;
   logic [WIDTH-1:0] rdata_b_d;
   logic [WIDTH-1:0] rdata_a_q;
   logic [WIDTH-1:0] rdata_b_q;
   logic             busy_a_d;
   logic             busy_b_d;
   logic             busy_a_q;
   logic             busy_b_q;

   // With ZERO_R0 the r0 slot is never written, so it stays zero.
   assign wr_en = bus.we &&
      !((ZERO_R0 != 0) && (bus.waddr == '0));

   always_comb begin
      rdata_a_d = mem_q[bus.raddr_a];
      rdata_b_d = mem_q[bus.raddr_b];
      if (wr_en && (bus.waddr == bus.raddr_a)) begin
         rdata_a_d = bus.wdata;
      end
      if (wr_en && (bus.waddr == bus.raddr_b)) begin
         rdata_b_d = bus.wdata;
      end
   end

   reg_file_scoreboard #(
      .DEPTH   (DEPTH),
      .ZERO_R0 (ZERO_R0)
   ) u_sb (
      .clk        (clk),
      .reset      (reset),
      .set_i      (bus.busy_set),
      .set_addr_i (bus.busy_addr),
      .clr_i      (bus.we),
      .clr_addr_i (bus.waddr),
      .raddr_a_i  (bus.raddr_a),
      .raddr_b_i  (bus.raddr_b),
      .busy_a_o   (busy_a_d),
      .busy_b_o   (busy_b_d)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         mem_q <= '{default: '0};
      end else if (wr_en) begin
         mem_q[bus.waddr] <= bus.wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rdata_a_q <= '0;
         rdata_b_q <= '0;
         busy_a_q  <= 1'b0;
         busy_b_q  <= 1'b0;
      end else if (bus.re) begin
         rdata_a_q <= rdata_a_d;
         rdata_b_q <= rdata_b_d;
         busy_a_q  <= busy_a_d;
         busy_b_q  <= busy_b_d;
      end
   end

   assign bus.rdata_a = rdata_a_q;
   assign bus.rdata_b = rdata_b_q;
   assign bus.busy_a  = busy_a_q;
   assign bus.busy_b  = busy_b_q;

endmodule

// File: tb/tb_reg_file.sv
// Randomised scoreboard bench for reg_file against an array model.
module tb_reg_file;
   import cpu_pkg::*;

   typedef struct {
      logic [15:0] ra;
      logic [15:0] rb;
      logic        ba;
      logic        bb;
   } exp_t;

   logic clk;
   logic reset;
   int   total;
   int   bad;
   exp_t exp_q[$];

   logic [15:0] m_mem [16];
   bit          m_busy [16];
   exp_t        m_out;

   reg_file_if bus ();

   reg_file #(
      .WIDTH   (16),
      .DEPTH   (16),
      .ZERO_R0 (1)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Architectural model: a read returns the state after this
   // cycle's write/clear/issue have taken effect.
   task automatic model_step();
      logic [15:0] nm [16];
      bit          nb [16];
      int          wa, sa, a, b;
      exp_t        e;
      if (reset) begin
         for (int i = 0; i < 16; i++) begin
            m_mem[i]  = '0;
            m_busy[i] = 1'b0;
         end
         m_out = '{16'h0, 16'h0, 1'b0, 1'b0};
      end else begin
         nm = m_mem;
         nb = m_busy;
         wa = int'(bus.waddr);
         sa = int'(bus.busy_addr);
         if (bus.we && wa != 0) nm[wa] = bus.wdata;
         if (bus.we) nb[wa] = 1'b0;
         if (bus.busy_set && sa != 0) nb[sa] = 1'b1;
         if (bus.re) begin
            a = int'(bus.raddr_a);
            b = int'(bus.raddr_b);
            m_out.ra = nm[a];
            m_out.rb = nm[b];
            m_out.ba = nb[a];
            m_out.bb = nb[b];
         end
         m_mem  = nm;
         m_busy = nb;
      end
      e = m_out;
      exp_q.push_back(e);
   endtask

   task automatic cyc(
      input bit rst, input bit we,
      input int wa, input logic [15:0] wd,
      input bit re, input int ra, input int rb,
      input bit bs, input int ba
   );
      @(negedge clk);
      reset         = rst;
      bus.we        = we;
      bus.waddr     = 4'(wa);
      bus.wdata     = wd;
      bus.re        = re;
      bus.raddr_a   = 4'(ra);
      bus.raddr_b   = 4'(rb);
      bus.busy_set  = bs;
      bus.busy_addr = 4'(ba);
      @(posedge clk);
      model_step();
   endtask

   task automatic chk(
      input string nm, input logic [15:0] act,
      input logic [15:0] want
   );
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s: got %h want %h at %0t",
                  nm, act, want, $time);
      end
   endtask

   // Monitor: outputs are registered, so each edge's expectation
   // is compared at the following falling edge.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("rdata_a", bus.rdata_a, e.ra);
            chk("rdata_b", bus.rdata_b, e.rb);
            chk("busy_a", {15'h0, bus.busy_a}, {15'h0, e.ba});
            chk("busy_b", {15'h0, bus.busy_b}, {15'h0, e.bb});
         end
      end
   end

   initial begin
      int n;
      total = 0;
      bad   = 0;
      reset = 1'b1;
      bus.we = 1'b0;
      bus.waddr = '0;
      bus.wdata = '0;
      bus.re = 1'b0;
      bus.raddr_a = '0;
      bus.raddr_b = '0;
      bus.busy_set = 1'b0;
      bus.busy_addr = '0;

      cyc(1, 0, 0, 16'h0, 0, 0, 0, 0, 0);
      cyc(1, 0, 0, 16'h0, 1, 0, 0, 0, 0);
      for (int i = 0; i < 16; i++)
         cyc(0, 0, 0, 16'h0, 1, i, 15 - i, 0, 0);

      cyc(0, 1, 5, 16'hBEEF, 0, 0, 0, 0, 0);
      cyc(0, 0, 0, 16'h0, 1, 5, 3, 0, 0);

      cyc(0, 1, 7, 16'h1234, 1, 7, 7, 0, 0);

      cyc(0, 1, 0, 16'hFFFF, 1, 0, 0, 1, 0);
      cyc(0, 0, 0, 16'h0, 1, 0, 0, 0, 0);

      cyc(0, 0, 0, 16'h0, 0, 0, 0, 1, 4);
      cyc(0, 0, 0, 16'h0, 1, 4, 4, 0, 0);
      cyc(0, 1, 4, 16'h00A5, 0, 0, 0, 1, 4);
      cyc(0, 0, 0, 16'h0, 1, 4, 0, 0, 0);
      cyc(0, 1, 4, 16'h5A5A, 0, 0, 0, 0, 0);
      cyc(0, 0, 0, 16'h0, 1, 4, 4, 0, 0);

      cyc(0, 1, 1, 16'h1111, 0, 0, 0, 0, 0);
      cyc(0, 1, 2, 16'h2222, 0, 0, 0, 1, 2);
      cyc(0, 1, 3, 16'h3333, 1, 1, 2, 0, 0);
      cyc(1, 1, 3, 16'h4444, 1, 3, 2, 1, 5);
      cyc(0, 0, 0, 16'h0, 1, 1, 2, 0, 0);
      cyc(0, 0, 0, 16'h0, 1, 3, 2, 0, 0);
      cyc(0, 0, 0, 16'h0, 0, 5, 6, 0, 0);
      cyc(0, 0, 0, 16'h0, 0, 7, 1, 0, 0);

      for (int k = 0; k < 800; k++) begin
         cyc(($urandom_range(0, 59) == 0),
             $urandom_range(0, 1),
             $urandom_range(0, 15),
             16'($urandom),
             ($urandom_range(0, 3) != 0),
             $urandom_range(0, 15),
             $urandom_range(0, 15),
             $urandom_range(0, 1),
             $urandom_range(0, 15));
      end

      n = 0;
      while (exp_q.size() > 0 && n < 10) begin
         @(negedge clk);
         n++;
      end
      @(posedge clk);
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL drain: %0d left want 0",
                  exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/reg_file.md
# reg_file

Parametrised CPU register file: one synchronous write port, two registered read ports with write-first bypass, and a per-register busy scoreboard for hazard detection. It replaces the standalone 16-bit enabled registers in the datapath. Decode reads operands and busy flags here. Writeback writes results and clears busy bits.

## Interface
Parameters:
- WIDTH, 16, data width of each register
- DEPTH, 16, number of registers; power of two, ≥2
- ZERO_R0, 1, when 1 register 0 is hardwired to zero and can never be busy
- AW, $clog2(DEPTH), address width (derived, not overridden)

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- we  in  1  write enable (writeback)
- waddr  in  AW  write address
- wdata  in  WIDTH  write data
- re  in  1  read enable; when 0, rdata_a/rdata_b/busy_a/busy_b hold their values
- raddr_a  in  AW  read address, port A
- raddr_b  in  AW  read address, port B
- rdata_a  out  WIDTH  registered read data, port A
- rdata_b  out  WIDTH  registered read data, port B
- busy_set  in  1  mark busy_addr as pending (instruction issue)
- busy_addr  in  AW  register to mark pending
- busy_a  out  1  registered busy flag for raddr_a
- busy_b  out  1  registered busy flag for raddr_b

## Operation
- Storage: DEPTH×WIDTH registers plus DEPTH busy bits.
- Write: when we=1, mem[waddr] <= wdata at the edge.
  - When we=1, busy[waddr] <= 0.
- Issue: when busy_set=1, busy[busy_addr] <= 1.
- Set and clear on the same address in the same cycle: set wins, so busy=1. The newly issued producer is outstanding.
- Read, when re=1: rdata_x <= mem[raddr_x] and busy_x <= busy[raddr_x].
- Write-first bypass: if we=1 and waddr==raddr_x in the same cycle, rdata_x <= wdata. busy_x reflects the post-update busy value for the same cycle, with set having priority over clear.
- Ports A and B are fully independent. Both may read the same address.
- ZERO_R0=1:
  - Writes to address 0 are discarded, including for the bypass.
  - Reads of address 0 return 0.
  - busy_set to address 0 is ignored, so busy_x for address 0 is always 0.
- ZERO_R0=0: address 0 is an ordinary register.

## Timing
- Read latency is 1 cycle. Addresses are presented in cycle N; rdata and busy are valid in cycle N+1 and held while re=0.
- Write latency is 1 cycle. A non-bypassed read of the same address in cycle N+1 returns the new value.
- Reset takes priority over we, busy_set and re. In the cycle after reset=1:
  - every register reads 0;
  - every busy bit is 0;
  - rdata_a, rdata_b, busy_a, busy_b = 0.
- Reset asserted mid-sequence discards pending writes and busy state in that cycle. Normal operation resumes on the first edge with reset=0.
- No combinational path from any input to any output.

## Structure
- Shared package cpu_pkg holds:
  - data width constant (16);
  - register count constant (16);
  - derived register address width;
  - register address typedef.
- One sub-module, reg_file_scoreboard, holds the busy-bit array:
  - inputs: set, clear, reset and the read addresses;
  - outputs: the pre-register busy lookups;
  - it owns the rule that set beats clear and the R0-never-busy rule.
- Data array, bypass mux and output registers live in reg_file.

## Test plan
- Reset, then read all addresses on both ports: every rdata = 0 and every busy = 0, one cycle after each address.
- Write 0xBEEF to r5, then read r5 on A and r3 on B next cycle: rdata_a = 0xBEEF and rdata_b = 0 one cycle later.
- Write 0x1234 to r7 while reading r7 on both ports in the same cycle: rdata_a = rdata_b = 0x1234 next cycle (bypass).
- ZERO_R0=1: write 0xFFFF to r0 and busy_set r0, then read r0: rdata = 0 and busy = 0, in the same cycle and the next.
- busy_set r4, then read r4: busy_a = 1. Then assert we to r4 with busy_set r4 in the same cycle, and read: busy_a = 1. Then we to r4 only, and read: busy_a = 0 and rdata = the last wdata.
- Load r1..r3 and set busy on r2, then assert reset for 1 cycle mid-stream: next-cycle reads of r1..r3 return 0 with busy 0, and a re=0 hold keeps rdata at 0.
